wide_addsub_seq: RTL
====================

WIDE_ADDSUB_SEQ -- requirements
Module: wide_addsub_seq

Interface
- REQ-001 Parameter W, default 128: total operand width in bits.
- REQ-002 Parameter N, default 32: slice width processed per cycle; W SHALL be an integer multiple of N; S = W/N.
- REQ-003 clk  input  1  single clock; all state updates on rising edge.
- REQ-004 rst_n  input  1  reset, synchronous and active-low.
- REQ-005 in_valid  input  1  operand request valid.
- REQ-006 in_ready  output  1  block can accept a request.
- REQ-007 op_sub  input  1  0 = A+B, 1 = A-B.
- REQ-008 a  input  W  operand A.
- REQ-009 b  input  W  operand B.
- REQ-010 out_valid  output  1  result and flags valid.
- REQ-011 out_ready  input  1  consumer accepts result.
- REQ-012 result  output  W  sum/difference.
- REQ-013 n_flag, z_flag, c_flag, v_flag  output  1 each  negative, zero, carry/borrow, signed overflow of the full W-bit operation.

Function
- REQ-014 FSM states: IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
- REQ-015 IDLE: on in_valid&&in_ready, latch a, b, op_sub; clear slice index, Z accumulator; set internal carry = op_sub; go BUSY.
- REQ-016 BUSY: each cycle compute slice idx (LSB first) as A_slice + (op_sub ? ~B_slice : B_slice) + carry; write result slice; register carry-out; idx increments.
- REQ-017 After slice S-1 is registered, go DONE; out_valid SHALL rise exactly S cycles after the accept edge.
- REQ-018 n_flag = result[W-1]; z_flag = 1 iff all W result bits are 0 (accumulated per slice).
- REQ-019 c_flag: add = final carry-out; sub = borrow = NOT final carry-out (1 iff A < B unsigned).
- REQ-020 v_flag = signed overflow from top slice: operands (post-inversion) same sign, result sign differs.
- REQ-021 DONE: outputs held stable while out_valid=1 and out_ready=0; on out_ready go IDLE same edge; no new accept in DONE.
- REQ-022 Inputs a, b, op_sub changing during BUSY/DONE SHALL have no effect.
- REQ-023 out_ready asserted outside DONE SHALL be ignored.
- REQ-024 Sustained throughput: one operation per S+2 cycles maximum.

Reset
- REQ-025 rst_n=0 at a rising edge: state IDLE, in_ready=1, out_valid=0, result=0, all flags 0, idx=0, carry=0.
- REQ-026 Reset mid-BUSY or mid-DONE SHALL abort the operation; no out_valid for it.

Configuration
- REQ-027 Macro WIDE_ADDSUB_SAT_EN defined: on v_flag=1, result SHALL clamp to signed max (0x7FF..F) if true result positive, signed min (0x800..0) if negative; flags n/z computed on clamped value, v_flag still 1.
- REQ-028 Macro undefined: result is the wrapped two's-complement value; no clamp logic present.

Structure
- REQ-029 Package wide_addsub_pkg: state enum (IDLE, BUSY, DONE), default W and N constants, flag struct {n,z,c,v}.
- REQ-030 One sub-module addsub_slice (N-bit, explicit carry-in, invert-B input, carry-out, top-slice overflow); FSM and registers in wide_addsub_seq.

Verification
- REQ-031 Add no carry: A=30, B=10, op_sub=0 -> after 4 cycles result=40, n=0 z=0 c=0 v=0.
- REQ-032 Cross-slice carry: A=0x0000..00FFFFFFFF, B=1, add -> result=0x0000..0100000000, c=0, z=0.
- REQ-033 Sub negative: A=10, B=30, op_sub=1 -> result=-20 (0xFFF..FEC), n=1 c=1 z=0 v=0.
- REQ-034 Sub zero: A=B=0x1234..., op_sub=1 -> result=0, z=1, c=0.
- REQ-035 Overflow: A=0x7FF..F, B=0xFFF..F, op_sub=1 -> without macro result=0x800..0, n=1 v=1 c=1; with WIDE_ADDSUB_SAT_EN result=0x7FF..F, n=0 v=1.
- REQ-036 Backpressure and reset: hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0; then rst_n=0 mid-BUSY on next op -> out_valid never rises, in_ready=1 next cycle.

Source files
------------

// File: rtl/wide_addsub_pkg.sv
// Shared types and defaults for the sequential wide adder/subtractor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default operand/slice widths, result flag struct.
package wide_addsub_pkg;

  localparam int DEFAULT_W = 128;
  localparam int DEFAULT_N = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/addsub_slice.sv
// One N-bit slice of the wide add/subtract datapath.
// Latency: combinational.
// Backpressure: none; the caller sequences slices.
//
// Ports: a, b (N-bit operands), cin (carry in), inv_b (use ~b for subtract),
//        sum (N-bit), cout (carry out), ovf (signed overflow if this is the top slice).
module addsub_slice #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         inv_b,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic [N-1:0] b_eff;

  always_comb begin
    b_eff       = inv_b ? ~b : b;
    {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, cin};
    // Same-sign operands producing an opposite-sign result.
    ovf         = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
  end

endmodule

// File: rtl/wide_addsub_seq.sv
// Sequential W-bit add/subtract, one N-bit slice per cycle, LSB slice first.
// Latency: out_valid rises S=W/N cycles after the accept edge; one op per S+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
//
// Ports: clk, rst_n (synchronous, active-low), in_valid/in_ready + op_sub/a/b request,
//        out_valid/out_ready + result and n/z/c/v flags.
// Option: define WIDE_ADDSUB_SAT_EN to clamp overflowed results to signed max/min.
module wide_addsub_seq
  import wide_addsub_pkg::*;
#(
  parameter int W = DEFAULT_W,
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         n_flag,
  output logic         z_flag,
  output logic         c_flag,
  output logic         v_flag
);

  localparam int S    = W / N;
  localparam int IDXW = (S > 1) ? $clog2(S) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(S - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic            zacc_q, zacc_d;   // OR of all slices written so far
  flags_t          flags_q, flags_d;

  logic [N-1:0]    slice_a;
  logic [N-1:0]    slice_b;
  logic [N-1:0]    slice_sum;
  logic            slice_cout;
  logic            slice_ovf;

  assign slice_a = a_q[idx_q*N +: N];
  assign slice_b = b_q[idx_q*N +: N];

  addsub_slice #(.N(N)) u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .cin   (carry_q),
    .inv_b (op_q),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .ovf   (slice_ovf)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zacc_d  = zacc_q;
    flags_d = flags_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op_sub;
          idx_d   = '0;
          zacc_d  = 1'b0;
          // Subtract is A + ~B + 1, so the +1 enters as the first carry-in.
          carry_d = op_sub;
          state_d = BUSY;
        end
      end

      BUSY: begin
        res_d[idx_q*N +: N] = slice_sum;
        zacc_d  = zacc_q | (|slice_sum);
        carry_d = slice_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          idx_d     = '0;
          state_d   = DONE;
          flags_d.n = slice_sum[N-1];
          flags_d.z = ~(zacc_q | (|slice_sum));
          // For subtract the flag reports borrow, the inverse of carry-out.
          flags_d.c = op_q ^ slice_cout;
          flags_d.v = slice_ovf;
`ifdef WIDE_ADDSUB_SAT_EN
          // On overflow the true result has A's sign (both effective operands share it).
          if (slice_ovf) begin
            res_d     = {a_q[W-1], {(W-1){~a_q[W-1]}}};
            flags_d.n = a_q[W-1];
            flags_d.z = 1'b0;
          end
`endif
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zacc_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zacc_q  <= zacc_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign n_flag    = flags_q.n;
  assign z_flag    = flags_q.z;
  assign c_flag    = flags_q.c;
  assign v_flag    = flags_q.v;

endmodule
